// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage.
//  Owns the architectural PC and picks the next fetch address from a clint redirect, an EX jump
//  or PC+4. It keeps at most one fetch outstanding on the instruction RAM bus and presents
//  pc/inst to the IF/ID register.
//  Optional feature macro: IFU_MISALIGN_TRAP_EN. When it is defined, a misaligned redirect target
//  raises a fetch fault slot. When it is not defined, the target is forced to word alignment.
// Ports:
//  clk, rst (sync, active-high)
//  stall_i                               PC-stage stall from clint
//  clint_pc_i / clint_pc_valid_i         trap/mret redirect (priority)
//  jump_pc_i / jump_valid_i              EX branch/jump redirect
//  ram_req_valid_o/ready_i/addr_o        fetch request channel
//  ram_resp_valid_i/data_i               fetch response channel
//  pc_o, inst_o, inst_valid_o, misalign_o  IF/ID slot
//  ram_stall_valid_if_o                  fetch outstanding, from state register only
module ifu_fetch #(
   parameter int unsigned     XLEN     = 64,
   parameter int unsigned     INST_LEN = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_i,
   input  logic [XLEN-1:0]     clint_pc_i,
   input  logic                clint_pc_valid_i,
   input  logic [XLEN-1:0]     jump_pc_i,
   input  logic                jump_valid_i,
   output logic                ram_req_valid_o,
   input  logic                ram_req_ready_i,
   output logic [XLEN-1:0]     ram_req_addr_o,
   input  logic                ram_resp_valid_i,
   input  logic [INST_LEN-1:0] ram_resp_data_i,
   output logic [XLEN-1:0]     pc_o,
   output logic [INST_LEN-1:0] inst_o,
   output logic                inst_valid_o,
   output logic                misalign_o,
   output logic                ram_stall_valid_if_o
);

   localparam logic [INST_LEN-1:0] NOP = INST_LEN'(32'h0000_0013);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

   state_t                state_q, state_d;
   logic [XLEN-1:0]       pc_q, pc_d;
   logic                  pending_q, pending_d;
   logic [XLEN-1:0]       pending_pc_q, pending_pc_d;
   logic                  halt_q, halt_d;
   logic                  req_valid_q, req_valid_d;
   logic [XLEN-1:0]       req_addr_q, req_addr_d;
   logic [XLEN-1:0]       pc_out_q, pc_out_d;
   logic [INST_LEN-1:0]   inst_q, inst_d;
   logic                  inst_valid_q, inst_valid_d;
   logic                  misalign_q, misalign_d;

   logic                  redir;
   logic [XLEN-1:0]       tgt_raw;
   logic [XLEN-1:0]       tgt;
   logic                  tgt_mis;

   // Redirect select: clint beats EX.
   assign redir   = clint_pc_valid_i | jump_valid_i;
   assign tgt_raw = clint_pc_valid_i ? clint_pc_i : jump_pc_i;

`ifdef IFU_MISALIGN_TRAP_EN
   assign tgt     = tgt_raw;
   assign tgt_mis = redir & (tgt_raw[1:0] != 2'b00);
`else
   assign tgt     = tgt_raw & ~XLEN'(3);
   assign tgt_mis = 1'b0;
`endif

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         pending_q    <= 1'b0;
         pending_pc_q <= '0;
         halt_q       <= 1'b0;
         req_valid_q  <= 1'b0;
         req_addr_q   <= '0;
         pc_out_q     <= '0;
         inst_q       <= NOP;
         inst_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pending_q    <= pending_d;
         pending_pc_q <= pending_pc_d;
         halt_q       <= halt_d;
         req_valid_q  <= req_valid_d;
         req_addr_q   <= req_addr_d;
         pc_out_q     <= pc_out_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         misalign_q   <= misalign_d;
      end
   end

   // Next-state and slot logic.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pending_d    = pending_q;
      pending_pc_d = pending_pc_q;
      halt_d       = halt_q;
      req_valid_d  = req_valid_q;
      req_addr_d   = req_addr_q;
      pc_out_d     = pc_out_q;
      inst_d       = inst_q;
      // The slot stays valid only while IF/ID is stalled.
      inst_valid_d = inst_valid_q & stall_i;
      misalign_d   = misalign_q & stall_i;

      // Any redirect kills the wrong-path slot. A misaligned target replaces the slot with a fault
      // and parks the fetcher until the next redirect.
      if (redir) begin
         inst_valid_d = 1'b0;
         misalign_d   = 1'b0;
         halt_d       = 1'b0;
      end
      if (tgt_mis) begin
         inst_valid_d = 1'b1;
         misalign_d   = 1'b1;
         pc_out_d     = tgt;
         inst_d       = NOP;
         halt_d       = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (redir) pc_d = tgt;
            if (!stall_i && !halt_d) begin
               req_valid_d = 1'b1;
               req_addr_d  = redir ? tgt : pc_q;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            // The request must stay stable, so a redirect is parked until the fetch drains.
            if (redir) begin
               pending_d    = 1'b1;
               pending_pc_d = tgt;
            end
            if (ram_req_ready_i) begin
               req_valid_d = 1'b0;
               state_d     = (pending_q || redir) ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (ram_resp_valid_i) begin
               if (redir) begin
                  pc_d    = tgt;
                  state_d = S_IDLE;
               end else begin
                  pc_out_d     = pc_q;
                  inst_d       = ram_resp_data_i;
                  inst_valid_d = 1'b1;
                  misalign_d   = 1'b0;
                  pc_d         = pc_q + XLEN'(4);
                  if (!stall_i && !halt_d) begin
                     req_valid_d = 1'b1;
                     req_addr_d  = pc_q + XLEN'(4);
                     state_d     = S_REQ;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end else if (redir) begin
               pending_d    = 1'b1;
               pending_pc_d = tgt;
               state_d      = S_DROP;
            end
         end
         S_DROP: begin
            if (redir) pending_pc_d = tgt;
            if (ram_resp_valid_i) begin
               pc_d      = redir ? tgt : pending_pc_q;
               pending_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign ram_req_valid_o      = req_valid_q;
   assign ram_req_addr_o       = req_addr_q;
   assign pc_o                 = pc_out_q;
   assign inst_o               = inst_q;
   assign inst_valid_o         = inst_valid_q;
   assign misalign_o           = misalign_q;
   assign ram_stall_valid_if_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch: directed vector table, hand sequences, randomized RAM/redirect run.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic [63:0] clint_pc_i;
   logic        clint_pc_valid_i;
   logic [63:0] jump_pc_i;
   logic        jump_valid_i;
   logic        ram_req_valid_o;
   logic        ram_req_ready_i;
   logic [63:0] ram_req_addr_o;
   logic        ram_resp_valid_i;
   logic [31:0] ram_resp_data_i;
   logic [63:0] pc_o;
   logic [31:0] inst_o;
   logic        inst_valid_o;
   logic        misalign_o;
   logic        ram_stall_valid_if_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ifu_fetch dut (
      .clk(clk), .rst(rst), .stall_i(stall_i),
      .clint_pc_i(clint_pc_i), .clint_pc_valid_i(clint_pc_valid_i),
      .jump_pc_i(jump_pc_i), .jump_valid_i(jump_valid_i),
      .ram_req_valid_o(ram_req_valid_o), .ram_req_ready_i(ram_req_ready_i),
      .ram_req_addr_o(ram_req_addr_o), .ram_resp_valid_i(ram_resp_valid_i),
      .ram_resp_data_i(ram_resp_data_i), .pc_o(pc_o), .inst_o(inst_o),
      .inst_valid_o(inst_valid_o), .misalign_o(misalign_o),
      .ram_stall_valid_if_o(ram_stall_valid_if_o)
   );

   typedef struct {
      logic        stall, rdy, resp;
      logic [31:0] data;
      logic        jv;
      logic [63:0] jpc;
      logic        cv;
      logic [63:0] cpc;
      logic        e_rv;
      logic [63:0] e_ra;
      logic        e_iv;
      logic [63:0] e_pc;
      logic [31:0] e_inst;
      logic        e_so;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic stall, input logic rdy, input logic resp,
                               input logic [31:0] data, input logic jv, input logic [63:0] jpc,
                               input logic cv, input logic [63:0] cpc, input logic e_rv,
                               input logic [63:0] e_ra, input logic e_iv, input logic [63:0] e_pc,
                               input logic [31:0] e_inst, input logic e_so);
      vec_t v;
      v.stall = stall; v.rdy = rdy; v.resp = resp; v.data = data;
      v.jv = jv; v.jpc = jpc; v.cv = cv; v.cpc = cpc;
      v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_pc = e_pc;
      v.e_inst = e_inst; v.e_so = e_so;
      return v;
   endfunction

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] mem(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
   endfunction

   task automatic idle_inputs();
      stall_i = 1'b0; clint_pc_valid_i = 1'b0; clint_pc_i = '0;
      jump_valid_i = 1'b0; jump_pc_i = '0; ram_req_ready_i = 1'b0;
      ram_resp_valid_i = 1'b0; ram_resp_data_i = '0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " req_valid"}, 64'(ram_req_valid_o), 64'd0);
      chk({tag, " req_addr"}, ram_req_addr_o, 64'd0);
      chk({tag, " pc_o"}, pc_o, 64'd0);
      chk({tag, " inst_o"}, 64'(inst_o), 64'h13);
      chk({tag, " inst_valid"}, 64'(inst_valid_o), 64'd0);
      chk({tag, " misalign"}, 64'(misalign_o), 64'd0);
      chk({tag, " stall_if"}, 64'(ram_stall_valid_if_o), 64'd0);
   endtask

   vec_t vt[$];

   localparam logic [63:0] B = 64'h8000_0000;
   localparam logic [31:0] NOPI = 32'h13;

   logic [63:0] exp_pc;
   logic        pend;
   logic [63:0] paddr;
   int          pcnt;
   logic        prev_rv, prev_rdy;
   logic [63:0] prev_addr;
   int          n_del;
   logic [63:0] tgt;

   initial begin
      idle_inputs();
      rst = 1'b1;
      @(posedge clk); @(posedge clk); @(negedge clk);
      chk_reset_outputs("reset");

      // stall rdy resp data jv jpc cv cpc | rv ra iv pc inst stall_if
      vt.push_back(mk(0,1,0,0,0,0,0,0, 1,B,        0,0,      NOPI,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B,        0,0,      NOPI,1));
      vt.push_back(mk(0,0,1,32'h11111111,0,0,0,0, 1,B+4, 1,B, 32'h11111111,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+4,      0,B,      32'h11111111,1));
      vt.push_back(mk(0,0,1,32'h22222222,0,0,0,0, 1,B+8, 1,B+4, 32'h22222222,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+8,      0,B+4,    32'h22222222,1));
      vt.push_back(mk(0,0,0,0,1,B+'h100,0,0, 0,B+8, 0,B+4,   32'h22222222,1));
      vt.push_back(mk(0,0,1,32'hDEADBEEF,0,0,0,0, 0,B+8, 0,B+4, 32'h22222222,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0, 1,B+'h100,  0,B+4,    32'h22222222,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+'h100,  0,B+4,    32'h22222222,1));
      vt.push_back(mk(0,0,1,32'h44444444,0,0,0,0, 1,B+'h104, 1,B+'h100, 32'h44444444,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+'h104,  0,B+'h100, 32'h44444444,1));
      vt.push_back(mk(0,0,1,32'h55555555,1,B+'h40,0,0, 0,B+'h104, 0,B+'h100, 32'h44444444,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0, 1,B+'h40,   0,B+'h100, 32'h44444444,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+'h40,   0,B+'h100, 32'h44444444,1));
      vt.push_back(mk(1,0,1,32'h66666666,0,0,0,0, 0,B+'h40, 1,B+'h40, 32'h66666666,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0, 0,B+'h40,   1,B+'h40, 32'h66666666,0));
      vt.push_back(mk(0,0,0,0,1,B+'h300,1,B+'h200, 1,B+'h200, 0,B+'h40, 32'h66666666,1));
      for (int i = 0; i < 5; i++)
         vt.push_back(mk(0,0,0,0,0,0,0,0, 1,B+'h200, 0,B+'h40, 32'h66666666,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+'h200,  0,B+'h40, 32'h66666666,1));
      vt.push_back(mk(1,0,1,32'h77777777,0,0,0,0, 0,B+'h200, 1,B+'h200, 32'h77777777,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0, 0,B+'h200,  1,B+'h200, 32'h77777777,0));
      vt.push_back(mk(1,0,0,0,0,0,0,0, 0,B+'h200,  1,B+'h200, 32'h77777777,0));
      vt.push_back(mk(0,0,0,0,0,0,0,0, 1,B+'h204,  0,B+'h200, 32'h77777777,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+'h204,  0,B+'h200, 32'h77777777,1));
      vt.push_back(mk(0,0,1,32'h88888888,0,0,0,0, 1,B+'h208, 1,B+'h204, 32'h88888888,1));
      vt.push_back(mk(0,1,0,0,0,0,0,0, 0,B+'h208,  0,B+'h204, 32'h88888888,1));

      rst = 1'b0;
      foreach (vt[i]) begin
         stall_i = vt[i].stall; ram_req_ready_i = vt[i].rdy;
         ram_resp_valid_i = vt[i].resp; ram_resp_data_i = vt[i].data;
         jump_valid_i = vt[i].jv; jump_pc_i = vt[i].jpc;
         clint_pc_valid_i = vt[i].cv; clint_pc_i = vt[i].cpc;
         @(negedge clk);
         chk($sformatf("vec%0d req_valid", i), 64'(ram_req_valid_o), 64'(vt[i].e_rv));
         chk($sformatf("vec%0d req_addr", i), ram_req_addr_o, vt[i].e_ra);
         chk($sformatf("vec%0d inst_valid", i), 64'(inst_valid_o), 64'(vt[i].e_iv));
         chk($sformatf("vec%0d pc_o", i), pc_o, vt[i].e_pc);
         chk($sformatf("vec%0d inst_o", i), 64'(inst_o), 64'(vt[i].e_inst));
         chk($sformatf("vec%0d stall_if", i), 64'(ram_stall_valid_if_o), 64'(vt[i].e_so));
      end

      // Reset while WAIT, then a late response on release must be ignored.
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midrst");
      rst = 1'b0; ram_resp_valid_i = 1'b1; ram_resp_data_i = 32'h99999999;
      @(negedge clk);
      chk("late_resp inst_valid", 64'(inst_valid_o), 64'd0);
      chk("late_resp req_valid", 64'(ram_req_valid_o), 64'd1);
      chk("late_resp req_addr", ram_req_addr_o, B);
      chk("late_resp stall_if", 64'(ram_stall_valid_if_o), 64'd1);

      // Misaligned redirect target.
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; stall_i = 1'b1; jump_valid_i = 1'b1; jump_pc_i = B + 2;
      @(negedge clk);
      idle_inputs();
`ifdef IFU_MISALIGN_TRAP_EN
      chk("mis slot inst_valid", 64'(inst_valid_o), 64'd1);
      chk("mis slot misalign", 64'(misalign_o), 64'd1);
      chk("mis slot pc_o", pc_o, B + 2);
      chk("mis slot inst_o", 64'(inst_o), 64'h13);
      chk("mis slot req_valid", 64'(ram_req_valid_o), 64'd0);
      @(negedge clk);
      chk("mis idle inst_valid", 64'(inst_valid_o), 64'd0);
      chk("mis idle misalign", 64'(misalign_o), 64'd0);
      chk("mis idle req_valid", 64'(ram_req_valid_o), 64'd0);
      @(negedge clk);
      chk("mis parked req_valid", 64'(ram_req_valid_o), 64'd0);
      chk("mis parked stall_if", 64'(ram_stall_valid_if_o), 64'd0);
`else
      chk("mis slot inst_valid", 64'(inst_valid_o), 64'd0);
      chk("mis slot misalign", 64'(misalign_o), 64'd0);
      chk("mis slot req_valid", 64'(ram_req_valid_o), 64'd0);
      @(negedge clk);
      chk("mis forced req_valid", 64'(ram_req_valid_o), 64'd1);
      chk("mis forced req_addr", ram_req_addr_o, B);
      chk("mis forced misalign", 64'(misalign_o), 64'd0);
`endif

      // Randomized run: RAM with random ready/latency, random redirects; model tracks the
      // architectural instruction stream the IF/ID slot must deliver.
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_pc = B; pend = 1'b0; paddr = '0; pcnt = 0;
      prev_rv = 1'b0; prev_rdy = 1'b0; prev_addr = '0; n_del = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         if (inst_valid_o) begin
            chk("rand pc_o", pc_o, exp_pc);
            chk("rand inst_o", 64'(inst_o), 64'(mem(exp_pc)));
            exp_pc = exp_pc + 64'd4;
            n_del++;
         end
         if (misalign_o) chk("rand misalign", 64'(misalign_o), 64'd0);
         if (ram_req_valid_o && pend) chk("rand two_outstanding", 64'd1, 64'd0);
         if (prev_rv && !prev_rdy) begin
            chk("rand req_hold_valid", 64'(ram_req_valid_o), 64'd1);
            chk("rand req_hold_addr", ram_req_addr_o, prev_addr);
         end

         ram_resp_valid_i = 1'b0;
         ram_resp_data_i  = '0;
         if (pend) begin
            if (pcnt == 0) begin
               ram_resp_valid_i = 1'b1;
               ram_resp_data_i  = mem(paddr);
               pend = 1'b0;
            end else begin
               pcnt--;
            end
         end
         ram_req_ready_i = ($urandom_range(0, 2) != 0) && !pend;
         if (ram_req_valid_o && ram_req_ready_i) begin
            pend  = 1'b1;
            paddr = ram_req_addr_o;
            pcnt  = int'($urandom_range(0, 2));
         end

         clint_pc_valid_i = 1'b0; jump_valid_i = 1'b0;
         if ($urandom_range(0, 19) == 0) begin
            if ($urandom_range(0, 7) == 0)
               tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
            else
               tgt = B + 64'($urandom_range(0, 4095));
`ifdef IFU_MISALIGN_TRAP_EN
            tgt = tgt & ~64'h3;
`endif
            if ($urandom_range(0, 1) == 0) begin
               clint_pc_valid_i = 1'b1; clint_pc_i = tgt;
               jump_valid_i = $urandom_range(0, 1) == 1;
               jump_pc_i = 64'($urandom) << 2;
            end else begin
               jump_valid_i = 1'b1; jump_pc_i = tgt;
            end
            exp_pc = tgt & ~64'h3;
         end
         prev_rv   = ram_req_valid_o;
         prev_rdy  = ram_req_ready_i;
         prev_addr = ram_req_addr_o;
      end
      chk("rand progress", 64'(n_del >= 200), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
